wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NR_SRC, default 4: number of functional-unit result sources.
REQ-002 Parameter NR_WB_PORTS, default 2: number of scoreboard write-back ports driven.
REQ-003 Parameter DEPTH, default 2: per-source buffer entries; power of two, at least 2.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  discard all buffered and incoming results.
REQ-007 src_valid_i  in  NR_SRC  source result valid.
REQ-008 src_ready_o  out  NR_SRC  source buffer can accept a result.
REQ-009 src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  scoreboard transaction ID of each result.
REQ-010 src_data_i  in  NR_SRC x 64  result data.
REQ-011 src_ex_i  in  NR_SRC x exception_t  exception or fflags of each result.
REQ-012 trans_id_o  out  NR_WB_PORTS x TRANS_ID_BITS  write-back transaction ID.
REQ-013 wbdata_o  out  NR_WB_PORTS x 64  write-back data.
REQ-014 ex_o  out  NR_WB_PORTS x exception_t  write-back exception.
REQ-015 wt_valid_o  out  NR_WB_PORTS  write-back valid.

Function
REQ-016 Each source SHALL own a FIFO of DEPTH entries holding {trans_id, data, ex}.
REQ-017 src_ready_o[s] SHALL equal "FIFO s not full" and SHALL NOT depend on same-cycle pops.
REQ-018 A result SHALL be pushed on the edge where src_valid_i[s] and src_ready_o[s] are both high and flush_i is low.
REQ-019 Write-back outputs SHALL be driven combinationally from FIFO heads; minimum latency is accept edge N to wt_valid_o high in cycle N+1.
REQ-020 Each cycle, the block SHALL grant up to NR_WB_PORTS non-empty FIFOs, scanning round-robin from pointer rr_q.
REQ-021 Port k SHALL carry the k-th granted source in scan order; ungranted ports SHALL drive wt_valid_o=0, trans_id_o=0, wbdata_o=0, ex_o=0.
REQ-022 The scoreboard applies no back-pressure: every granted head SHALL be popped on the same edge.
REQ-023 If any grant occurs, rr_q SHALL update to (last granted source + 1) mod NR_SRC; otherwise rr_q SHALL hold.
REQ-024 Simultaneous push and pop on the same FIFO SHALL be allowed, with occupancy unchanged; if the FIFO is full, only the pop happens, because ready is low.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with $clog2(DEPTH)+1 bits.
REQ-026 flush_i high SHALL force wt_valid_o to all zeros in that cycle, drop any same-cycle push, empty all FIFOs, and set rr_q=0 on the next edge.
REQ-027 Entries SHALL pass through unmodified; ex.valid and ex.cause SHALL be forwarded bit-exact.
REQ-028 No two asserted wt_valid_o bits SHALL carry the same trans_id_o; this is guaranteed by unique scoreboard IDs and checked by assertion.

Reset
REQ-029 Reset SHALL asynchronously empty all FIFOs and clear their pointers and counts, and set rr_q=0.
REQ-030 During and after reset, outputs SHALL be: src_ready_o all ones, wt_valid_o zero, trans_id_o/wbdata_o/ex_o zero.
REQ-031 Reset asserted mid-operation SHALL discard buffered results without producing any write-back.

Structure
REQ-032 exception_t and TRANS_ID_BITS SHALL come from ariane_pkg; the block SHALL add no new package types.
REQ-033 The per-source buffer SHALL be one sub-module, wb_src_fifo, instantiated NR_SRC times, with ports push, pop, full, empty, flush and data.
REQ-034 Round-robin grant logic SHALL reside in wb_arbiter.

Verification
REQ-035 Single result: at cycle 0, src 2 presents ID 5 and data 0xAB -> in cycle 1, port 0 shows valid, ID 5 and data 0xAB, and port 1 is idle.
REQ-036 All four sources push in the same cycle with rr_q=0 -> cycle 1 grants src 0 and 1; cycle 2 grants src 2 and 3; rr_q is 0 afterwards.
REQ-037 Src 1 pushes 3 results while never granted (other sources kept busy) -> src_ready_o[1] falls after 2 accepts, and the third push waits.
REQ-038 Two results are buffered and flush_i is pulsed -> wt_valid_o is 0 during flush and the following cycle, and src_ready_o returns to all ones.
REQ-039 A source pushes ex.valid=1 with cause 0x5 -> the same ex appears on the granted port one cycle later.
REQ-040 Fairness: sources 0 and 3 push continuously with NR_WB_PORTS=1 -> grants alternate, with neither source starved for more than 1 cycle.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core package slice: scoreboard transaction-ID width and the exception record
// carried alongside every functional-unit result.
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

endpackage

// File: rtl/wb_arbiter_pkg.sv
// Write-back arbiter constants: result width, flattened buffer-entry width and an
// index-width helper that stays at least one bit wide.
package wb_arbiter_pkg;

    import ariane_pkg::*;

    localparam int unsigned WB_DATA_W  = 64;
    localparam int unsigned WB_ENTRY_W = TRANS_ID_BITS + WB_DATA_W + $bits(exception_t);

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result buffer: DEPTH-entry FIFO with the head visible combinationally,
// push refused when full, pop ignored when empty, flush empties it on the next edge.
module wb_src_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o & ~flush_i;
    assign w_pop   = pop_i & ~empty_o & ~flush_i;
    assign data_o  = r_mem[r_rd_ptr];

    // Payload storage needs no reset: the head is only consumed when the count says so.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Buffers functional-unit results per source and drains up to NR_WB_PORTS of them per
// cycle onto the scoreboard write-back ports in round-robin order.
module wb_arbiter
    import ariane_pkg::*;
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NR_SRC      = 4,
    parameter int unsigned NR_WB_PORTS = 2,
    parameter int unsigned DEPTH       = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         flush_i,
    input  logic [NR_SRC-1:0]                            src_valid_i,
    output logic [NR_SRC-1:0]                            src_ready_o,
    input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]         src_trans_id_i,
    input  logic [NR_SRC-1:0][WB_DATA_W-1:0]             src_data_i,
    input  exception_t [NR_SRC-1:0]                      src_ex_i,
    output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    trans_id_o,
    output logic [NR_WB_PORTS-1:0][WB_DATA_W-1:0]        wbdata_o,
    output exception_t [NR_WB_PORTS-1:0]                 ex_o,
    output logic [NR_WB_PORTS-1:0]                       wt_valid_o
);

    localparam int unsigned SRC_W  = idx_w(NR_SRC);
    localparam int unsigned PORT_W = idx_w(NR_WB_PORTS);

    logic [NR_SRC-1:0]                 w_full;
    logic [NR_SRC-1:0]                 w_empty;
    logic [NR_SRC-1:0]                 w_push;
    logic [NR_SRC-1:0]                 w_pop;
    logic [NR_SRC-1:0][WB_ENTRY_W-1:0] w_head;

    logic [SRC_W-1:0] r_rr;
    logic [SRC_W-1:0] w_rr_next;
    logic [SRC_W:0]   w_scan_sum;
    logic [SRC_W-1:0] w_scan_idx;
    logic [PORT_W:0]  w_port_cnt;
    logic             w_any_grant;
    logic [SRC_W-1:0] w_last;

    for (genvar gi = 0; gi < NR_SRC; gi++) begin : g_src
        assign w_push[gi] = src_valid_i[gi] & ~w_full[gi] & ~flush_i;

        wb_src_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (WB_ENTRY_W)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (w_push[gi]),
            .pop_i   (w_pop[gi]),
            .data_i  ({src_trans_id_i[gi], src_data_i[gi], src_ex_i[gi]}),
            .data_o  (w_head[gi]),
            .full_o  (w_full[gi]),
            .empty_o (w_empty[gi])
        );
    end

    // Ready is purely "not full", so a source never sees a path through the grant logic.
    assign src_ready_o = ~w_full;

    // Walk the sources starting at r_rr; the k-th non-empty one lands on port k.
    always_comb begin
        w_pop       = '0;
        wt_valid_o  = '0;
        trans_id_o  = '0;
        wbdata_o    = '0;
        ex_o        = '0;
        w_port_cnt  = '0;
        w_any_grant = 1'b0;
        w_last      = r_rr;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            w_scan_sum = {1'b0, r_rr} + (SRC_W+1)'(i);
            if (w_scan_sum >= (SRC_W+1)'(NR_SRC)) begin
                w_scan_sum = w_scan_sum - (SRC_W+1)'(NR_SRC);
            end
            w_scan_idx = w_scan_sum[SRC_W-1:0];
            if (!flush_i && !w_empty[w_scan_idx] &&
                (w_port_cnt < (PORT_W+1)'(NR_WB_PORTS))) begin
                w_pop[w_scan_idx] = 1'b1;
                wt_valid_o[w_port_cnt[PORT_W-1:0]] = 1'b1;
                {trans_id_o[w_port_cnt[PORT_W-1:0]],
                 wbdata_o[w_port_cnt[PORT_W-1:0]],
                 ex_o[w_port_cnt[PORT_W-1:0]]} = w_head[w_scan_idx];
                w_port_cnt  = w_port_cnt + (PORT_W+1)'(1);
                w_any_grant = 1'b1;
                w_last      = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_rr_next = r_rr;
        if (flush_i) begin
            w_rr_next = '0;
        end else if (w_any_grant) begin
            w_rr_next = (w_last == SRC_W'(NR_SRC - 1)) ? '0 : w_last + SRC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else begin
            r_rr <= w_rr_next;
        end
    end

    // Scoreboard IDs are unique in flight, so two live ports must never share one.
    for (genvar gi = 0; gi < NR_WB_PORTS; gi++) begin : g_uid_a
        for (genvar gj = gi + 1; gj < NR_WB_PORTS; gj++) begin : g_uid_b
            a_unique_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(wt_valid_o[gi] && wt_valid_o[gj] && (trans_id_o[gi] == trans_id_o[gj])));
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter, checked against a queue-based model
// of the per-source buffers and the round-robin drain order.
module tb_wb_arbiter;

    import ariane_pkg::*;

    localparam int NS    = 4;
    localparam int NP    = 2;
    localparam int DEPTH = 2;
    localparam int NID   = 1 << TRANS_ID_BITS;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] tid;
        logic [63:0]              data;
        exception_t               ex;
    } ent_t;

    logic                                clk_i = 1'b0;
    logic                                rst_ni;
    logic                                flush_i;
    logic [NS-1:0]                       src_valid_i;
    logic [NS-1:0]                       src_ready_o;
    logic [NS-1:0][TRANS_ID_BITS-1:0]    src_trans_id_i;
    logic [NS-1:0][63:0]                 src_data_i;
    exception_t [NS-1:0]                 src_ex_i;
    logic [NP-1:0][TRANS_ID_BITS-1:0]    trans_id_o;
    logic [NP-1:0][63:0]                 wbdata_o;
    exception_t [NP-1:0]                 ex_o;
    logic [NP-1:0]                       wt_valid_o;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(
        .NR_SRC      (NS),
        .NR_WB_PORTS (NP),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .src_valid_i    (src_valid_i),
        .src_ready_o    (src_ready_o),
        .src_trans_id_i (src_trans_id_i),
        .src_data_i     (src_data_i),
        .src_ex_i       (src_ex_i),
        .trans_id_o     (trans_id_o),
        .wbdata_o       (wbdata_o),
        .ex_o           (ex_o),
        .wt_valid_o     (wt_valid_o)
    );

    // Reference state: one queue per source, a scan start, and the IDs still in flight.
    ent_t          mq [NS][$];
    int            rr_m;
    bit            id_busy [NID];
    logic [NS-1:0] dir_en;
    ent_t          dir_ent [NS];
    int            n_cmp;
    int            n_bad;
    int            cyc;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) mq[s].delete();
        for (int i = 0; i < NID; i++) id_busy[i] = 1'b0;
        rr_m = 0;
    endtask

    // One cycle: drive at the falling edge, compare outputs, then advance the model.
    task automatic step(input logic [NS-1:0] want, input logic fl);
        ent_t          e;
        ent_t          exp_port [NP];
        logic [NP-1:0] exp_v;
        logic [NS-1:0] acc;
        bit            used [NID];
        bit            ok;
        int            st, c, k, s, last;
        int            gsrc [$];
        @(negedge clk_i);
        flush_i = fl;
        for (int i = 0; i < NID; i++) used[i] = 1'b0;
        for (int si = 0; si < NS; si++) begin
            ok = 1'b0;
            e  = '0;
            if (want[si]) begin
                if (dir_en[si]) begin
                    e  = dir_ent[si];
                    ok = 1'b1;
                end else begin
                    st = $urandom_range(0, NID - 1);
                    for (int j = 0; j < NID; j++) begin
                        c = (st + j) % NID;
                        if (!ok && !id_busy[c] && !used[c]) begin
                            ok    = 1'b1;
                            e.tid = TRANS_ID_BITS'(c);
                        end
                    end
                    e.data     = {$urandom(), $urandom()};
                    e.ex.cause = 64'($urandom_range(0, 15));
                    e.ex.tval  = {$urandom(), $urandom()};
                    e.ex.valid = 1'($urandom_range(0, 1));
                end
                if (ok) used[e.tid] = 1'b1;
            end
            if (!ok) begin
                e.tid  = TRANS_ID_BITS'($urandom_range(0, NID - 1));
                e.data = {$urandom(), $urandom()};
            end
            src_valid_i[si]    = ok;
            src_trans_id_i[si] = e.tid;
            src_data_i[si]     = e.data;
            src_ex_i[si]       = e.ex;
        end
        #1;
        for (int si = 0; si < NS; si++) begin
            acc[si] = src_valid_i[si] && (mq[si].size() < DEPTH) && !fl;
            check_eq($sformatf("ready%0d", si), 160'(src_ready_o[si]), 160'(mq[si].size() < DEPTH));
        end
        exp_v = '0;
        k     = 0;
        last  = -1;
        for (int p = 0; p < NP; p++) exp_port[p] = '0;
        if (!fl) begin
            for (int i = 0; i < NS; i++) begin
                s = (rr_m + i) % NS;
                if (mq[s].size() > 0 && k < NP) begin
                    exp_port[k] = mq[s][0];
                    exp_v[k]    = 1'b1;
                    gsrc.push_back(s);
                    last = s;
                    k++;
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            check_eq($sformatf("valid%0d", p), 160'(wt_valid_o[p]), 160'(exp_v[p]));
            check_eq($sformatf("tid%0d", p), 160'(trans_id_o[p]), 160'(exp_port[p].tid));
            check_eq($sformatf("data%0d", p), 160'(wbdata_o[p]), 160'(exp_port[p].data));
            check_eq($sformatf("ex%0d", p), 160'(ex_o[p]), 160'(exp_port[p].ex));
            if (exp_v[p])
                $display("cyc %0d wb port %0d src %0d id %0d data %h", cyc, p, gsrc[p],
                         exp_port[p].tid, exp_port[p].data);
        end
        if (fl) begin
            model_clear();
        end else begin
            foreach (gsrc[i]) begin
                e = mq[gsrc[i]].pop_front();
                id_busy[e.tid] = 1'b0;
            end
            for (int si = 0; si < NS; si++) begin
                if (acc[si]) begin
                    e.tid  = src_trans_id_i[si];
                    e.data = src_data_i[si];
                    e.ex   = src_ex_i[si];
                    mq[si].push_back(e);
                    id_busy[e.tid] = 1'b1;
                end
            end
            if (last >= 0) rr_m = (last + 1) % NS;
        end
        cyc++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, 160'(src_ready_o), 160'({NS{1'b1}}));
        check_eq({tag, "_valid"}, 160'(wt_valid_o), 160'(0));
        check_eq({tag, "_tid"}, 160'(trans_id_o), 160'(0));
        check_eq({tag, "_data"}, 160'(wbdata_o), 160'(0));
        check_eq({tag, "_ex"}, 160'(ex_o), 160'(0));
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk_i);
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        src_valid_i = '0;
        #1;
        check_idle_outputs("rst_async");
        repeat (ncyc) @(negedge clk_i);
        check_idle_outputs("rst_hold");
        rst_ni = 1'b1;
        model_clear();
    endtask

    task automatic set_dir(input int s, input int tid, input logic [63:0] data,
                           input logic exv, input logic [63:0] cause);
        dir_en[s]           = 1'b1;
        dir_ent[s].tid      = TRANS_ID_BITS'(tid);
        dir_ent[s].data     = data;
        dir_ent[s].ex.valid = exv;
        dir_ent[s].ex.cause = cause;
        dir_ent[s].ex.tval  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        cyc            = 0;
        dir_en         = '0;
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        src_valid_i    = '0;
        src_trans_id_i = '0;
        src_data_i     = '0;
        src_ex_i       = '0;
        model_clear();
        do_reset(3);

        // Single result from src 2 appears on port 0 one cycle later.
        set_dir(2, 5, 64'hAB, 1'b0, 64'h0);
        step(4'b0100, 1'b0);
        dir_en = '0;
        step(4'b0000, 1'b0);
        check_eq("single_valid", 160'(wt_valid_o), 160'(2'b01));
        check_eq("single_tid", 160'(trans_id_o[0]), 160'(5));
        check_eq("single_data", 160'(wbdata_o[0]), 160'(64'hAB));
        check_eq("single_p1_idle", 160'(trans_id_o[1]), 160'(0));

        // All four push together from rr=0: pairs (0,1) then (2,3), pointer back at 0.
        step(4'b0000, 1'b1);
        for (int s = 0; s < NS; s++) set_dir(s, s, 64'h100 + 64'(s), 1'b0, 64'h0);
        step(4'b1111, 1'b0);
        dir_en = '0;
        step(4'b0000, 1'b0);
        check_eq("all4_c1_valid", 160'(wt_valid_o), 160'(2'b11));
        check_eq("all4_c1_tid0", 160'(trans_id_o[0]), 160'(0));
        check_eq("all4_c1_tid1", 160'(trans_id_o[1]), 160'(1));
        step(4'b0000, 1'b0);
        check_eq("all4_c2_tid0", 160'(trans_id_o[0]), 160'(2));
        check_eq("all4_c2_tid1", 160'(trans_id_o[1]), 160'(3));
        step(4'b0000, 1'b0);
        check_eq("all4_c3_valid", 160'(wt_valid_o), 160'(0));
        set_dir(0, 4, 64'h40, 1'b0, 64'h0);
        set_dir(3, 6, 64'h60, 1'b0, 64'h0);
        step(4'b1001, 1'b0);
        dir_en = '0;
        step(4'b0000, 1'b0);
        check_eq("rr0_tid0", 160'(trans_id_o[0]), 160'(4));
        check_eq("rr0_tid1", 160'(trans_id_o[1]), 160'(6));

        // Src 1 fills while the pointer skips it; its ready drops after two accepts.
        step(4'b0000, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1110, 1'b0);
        step(4'b0010, 1'b0);
        check_eq("src1_full_ready", 160'(src_ready_o[1]), 160'(0));
        step(4'b0010, 1'b0);
        check_eq("src1_ready_back", 160'(src_ready_o[1]), 160'(1));

        // Exception fields pass through bit-exact.
        step(4'b0000, 1'b1);
        set_dir(1, 2, 64'hDEAD, 1'b1, 64'h5);
        step(4'b0010, 1'b0);
        dir_en = '0;
        step(4'b0000, 1'b0);
        check_eq("ex_valid", 160'(ex_o[0].valid), 160'(1));
        check_eq("ex_cause", 160'(ex_o[0].cause), 160'(64'h5));

        // Flush with two results buffered: nothing written back, buffers emptied.
        step(4'b0000, 1'b1);
        step(4'b0101, 1'b0);
        step(4'b0010, 1'b1);
        check_eq("flush_valid", 160'(wt_valid_o), 160'(0));
        step(4'b0000, 1'b0);
        check_eq("post_flush_valid", 160'(wt_valid_o), 160'(0));
        check_eq("post_flush_ready", 160'(src_ready_o), 160'({NS{1'b1}}));

        // Sources 0 and 3 stream continuously; both must drain every cycle.
        step(4'b0000, 1'b1);
        step(4'b1001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(4'b1001, 1'b0);
            check_eq("stream_both", 160'(wt_valid_o), 160'(2'b11));
        end

        // Random traffic with occasional flushes and one mid-run reset.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                do_reset(2);
                step(4'b0000, 1'b0);
                check_eq("post_reset_valid", 160'(wt_valid_o), 160'(0));
            end
            step(NS'($urandom()), ($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
